// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: request, shift-register and serial-pin signals of one shift_sequencer.
// The abort request exists only when SHIFT_SEQUENCER_ABORT_EN is defined.
interface shift_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] txData;
    logic [WIDTH-1:0] shiftParOut;
    logic             shiftLoad;
    logic [WIDTH-1:0] shiftData;
    logic             shiftEdge;
    logic             sclk;
    logic             cs_n;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] rxData;
`ifdef SHIFT_SEQUENCER_ABORT_EN
    logic             abort;

    modport master (
        output start, txData, shiftParOut, abort,
        input  shiftLoad, shiftData, shiftEdge, sclk, cs_n, busy, done, rxData
    );

    modport slave (
        input  start, txData, shiftParOut, abort,
        output shiftLoad, shiftData, shiftEdge, sclk, cs_n, busy, done, rxData
    );
`else
    modport master (
        output start, txData, shiftParOut,
        input  shiftLoad, shiftData, shiftEdge, sclk, cs_n, busy, done, rxData
    );

    modport slave (
        input  start, txData, shiftParOut,
        output shiftLoad, shiftData, shiftEdge, sclk, cs_n, busy, done, rxData
    );
`endif
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer: loads the shift register, issues WIDTH evenly spaced shift strobes with a
// divided sclk and cs_n, then captures the received word. Define SHIFT_SEQUENCER_ABORT_EN for abort.
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             Clk,
    input  logic             Rst_n,
    shift_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_e;

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W = $clog2(WIDTH + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    state_e             state_q,      state_d;
    logic [DIV_W-1:0]   div_cnt_q,    div_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q,    bit_cnt_d;
    logic               shift_load_q, shift_load_d;
    logic [WIDTH-1:0]   shift_data_q, shift_data_d;
    logic               shift_edge_q, shift_edge_d;
    logic               sclk_q,       sclk_d;
    logic               cs_n_q,       cs_n_d;
    logic               busy_q,       busy_d;
    logic               done_q,       done_d;
    logic [WIDTH-1:0]   rx_data_q,    rx_data_d;
    logic               abort_req;

`ifdef SHIFT_SEQUENCER_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        div_cnt_d    = div_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_data_d = shift_data_q;
        rx_data_d    = rx_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d      = S_LOAD;
                    shift_data_d = bus.txData;
                end
            end
            S_LOAD: begin
                div_cnt_d = '0;
                bit_cnt_d = '0;
                state_d   = abort_req ? S_IDLE : S_SHIFT;
            end
            S_SHIFT: begin
                if (abort_req) begin
                    state_d = S_IDLE;
                end else if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = S_DONE;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            S_DONE: begin
                rx_data_d = bus.shiftParOut;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they appear registered in the cycle they describe.
        shift_load_d = (state_d == S_LOAD);
        shift_edge_d = (state_d == S_SHIFT) && (div_cnt_d == DIV_LAST);
        sclk_d       = (state_d == S_SHIFT) && (div_cnt_d >= DIV_HALF);
        busy_d       = (state_d != S_IDLE);
        cs_n_d       = (state_d == S_IDLE);
        done_d       = (state_d == S_DONE);
    end

    // NOTE: state uses non-blocking assignments; the data words are reset too since both have a defined reset value.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= S_IDLE;
            div_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shift_load_q <= 1'b0;
            shift_data_q <= '0;
            shift_edge_q <= 1'b0;
            sclk_q       <= 1'b0;
            cs_n_q       <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rx_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_load_q <= shift_load_d;
            shift_data_q <= shift_data_d;
            shift_edge_q <= shift_edge_d;
            sclk_q       <= sclk_d;
            cs_n_q       <= cs_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rx_data_q    <= rx_data_d;
        end
    end

    assign bus.shiftLoad = shift_load_q;
    assign bus.shiftData = shift_data_q;
    assign bus.shiftEdge = shift_edge_q;
    assign bus.sclk      = sclk_q;
    assign bus.cs_n      = cs_n_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rxData    = rx_data_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: transfer-phase model plus a shift-register peripheral, checked every cycle,
// with directed transfers pinned by hand-computed cycle numbers. Honours SHIFT_SEQUENCER_ABORT_EN.
module tb_shift_sequencer;

    localparam int W     = 8;
    localparam int D     = 4;
    localparam int TOTAL = W * D + 2;

    logic Clk;
    logic Rst_n;
    logic checking;
    int   total;
    int   bad;

    shift_sequencer_if #(.WIDTH(W)) bus ();

    shift_sequencer #(.WIDTH(W), .DIV(D)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Peripheral: parallel load, then shift rx_word in MSB-first on each strobe.
    logic [W-1:0] rx_word;
    logic [W-1:0] sr;
    logic [W-1:0] rx_sh;

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sr    <= '0;
            rx_sh <= '0;
        end else if (bus.shiftLoad) begin
            sr    <= bus.shiftData;
            rx_sh <= rx_word;
        end else if (bus.shiftEdge) begin
            sr    <= {sr[W-2:0], rx_sh[W-1]};
            rx_sh <= {rx_sh[W-2:0], 1'b0};
        end
    end
    assign bus.shiftParOut = sr;

    // Model: t is the cycle number within the current transfer (0 = idle).
    int           t;
    logic [W-1:0] m_data;
    logic [W-1:0] m_rx;

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            t      <= 0;
            m_data <= '0;
            m_rx   <= '0;
        end else if (t == 0) begin
            if (bus.start) begin
                t      <= 1;
                m_data <= bus.txData;
            end
`ifdef SHIFT_SEQUENCER_ABORT_EN
        end else if (bus.abort && t <= 1 + W * D) begin
            t <= 0;
`endif
        end else if (t == TOTAL) begin
            t    <= 0;
            m_rx <= rx_word;
        end else begin
            t <= t + 1;
        end
    end

    function automatic logic exp_edge(input int tt);
        return (tt >= 2) && (tt <= 1 + W * D) && (((tt - 1) % D) == 0);
    endfunction

    function automatic logic exp_sclk(input int tt);
        return (tt >= 2) && (tt <= 1 + W * D) && (((tt - 2) % D) >= D / 2);
    endfunction

    always @(negedge Clk) begin
        if (checking) begin
            check("model_shiftLoad", 32'(bus.shiftLoad), 32'(t == 1));
            check("model_shiftEdge", 32'(bus.shiftEdge), 32'(exp_edge(t)));
            check("model_sclk",      32'(bus.sclk),      32'(exp_sclk(t)));
            check("model_busy",      32'(bus.busy),      32'(t != 0));
            check("model_cs_n",      32'(bus.cs_n),      32'(t == 0));
            check("model_done",      32'(bus.done),      32'(t == TOTAL));
            check("model_shiftData", 32'(bus.shiftData), 32'(m_data));
            check("model_rxData",    32'(bus.rxData),    32'(m_rx));
        end
    end

    // Per-window statistics; cycle c=1 is the first cycle after the call.
    int n_load, last_load, load_data;
    int n_edge, first_edge, last_edge, n_both;
    int n_done, done_cyc;
    int n_busy, first_busy, last_busy;
    int n_csn, n_sclk_hi, n_sclk_rise;

    task automatic go(input logic [W-1:0] tx, input logic [W-1:0] rx);
        bus.txData = tx;
        rx_word    = rx;
        bus.start  = 1'b1;
    endtask

    task automatic run_window(input int ncyc, input int s_a, input int s_b, input int s_c);
        logic prev_sclk;
        prev_sclk = 1'b0;
        n_load = 0; last_load = 0; load_data = 0;
        n_edge = 0; first_edge = 0; last_edge = 0; n_both = 0;
        n_done = 0; done_cyc = 0;
        n_busy = 0; first_busy = 0; last_busy = 0;
        n_csn = 0; n_sclk_hi = 0; n_sclk_rise = 0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge Clk);
            bus.start = (c == s_a) || (c == s_b) || (c == s_c);
`ifdef SHIFT_SEQUENCER_ABORT_EN
            bus.abort = 1'b0;
`endif
            if (bus.shiftLoad) begin
                n_load++;
                last_load = c;
                if (n_load == 1) load_data = int'(bus.shiftData);
            end
            if (bus.shiftEdge) begin
                n_edge++;
                if (first_edge == 0) first_edge = c;
                last_edge = c;
            end
            if (bus.shiftLoad && bus.shiftEdge) n_both++;
            if (bus.done) begin
                n_done++;
                done_cyc = c;
            end
            if (bus.busy) begin
                n_busy++;
                if (first_busy == 0) first_busy = c;
                last_busy = c;
            end
            if (!bus.cs_n) n_csn++;
            if (bus.sclk) n_sclk_hi++;
            if (bus.sclk && !prev_sclk) n_sclk_rise++;
            prev_sclk = bus.sclk;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checking   = 1'b0;
        total      = 0;
        bad        = 0;
        bus.start  = 1'b0;
        bus.txData = '0;
        rx_word    = '0;
`ifdef SHIFT_SEQUENCER_ABORT_EN
        bus.abort  = 1'b0;
`endif
        Rst_n = 1'b1;
        #1 Rst_n = 1'b0;
        checking = 1'b1;

        // Reset values while held, then after release.
        repeat (3) @(negedge Clk);
        check("rst_cs_n",      32'(bus.cs_n),      32'd1);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_shiftData", 32'(bus.shiftData), 32'h00);
        check("rst_rxData",    32'(bus.rxData),    32'h00);
        Rst_n = 1'b1;
        @(negedge Clk);
        check("rel_cs_n",      32'(bus.cs_n),      32'd1);
        check("rel_shiftLoad", 32'(bus.shiftLoad), 32'd0);

        // Basic transfer: tx A5, peripheral returns 3C.
        go(8'hA5, 8'h3C);
        run_window(40, 0, 0, 0);
        check("basic_load_count", 32'(n_load),      32'd1);
        check("basic_load_cycle", 32'(last_load),   32'd1);
        check("basic_load_data",  32'(load_data),   32'hA5);
        check("basic_edges",      32'(n_edge),      32'd8);
        check("basic_first_edge", 32'(first_edge),  32'd5);
        check("basic_last_edge",  32'(last_edge),   32'd33);
        check("basic_load_edge",  32'(n_both),      32'd0);
        check("basic_done_count", 32'(n_done),      32'd1);
        check("basic_done_cycle", 32'(done_cyc),    32'd34);
        check("basic_busy_count", 32'(n_busy),      32'd34);
        check("basic_busy_first", 32'(first_busy),  32'd1);
        check("basic_busy_last",  32'(last_busy),   32'd34);
        check("basic_cs_n_low",   32'(n_csn),       32'd34);
        check("basic_sclk_rises", 32'(n_sclk_rise), 32'd8);
        check("basic_sclk_high",  32'(n_sclk_hi),   32'd16);
        check("basic_rxData",     32'(bus.rxData),  32'h3C);
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            check("idle_rx_hold", 32'(bus.rxData), 32'h3C);
        end

        // Starts in SHIFT (10) and DONE (34) ignored; start in 35 accepted.
        go(8'h5A, 8'hC3);
        run_window(36, 10, 34, 35);
        check("ign_load_count", 32'(n_load),     32'd2);
        check("ign_load_cycle", 32'(last_load),  32'd36);
        check("ign_done_count", 32'(n_done),     32'd1);
        check("ign_done_cycle", 32'(done_cyc),   32'd34);
        check("ign_edges",      32'(n_edge),     32'd8);
        check("ign_rxData",     32'(bus.rxData), 32'hC3);
        run_window(40, 0, 0, 0);
        check("b2b_done_cycle", 32'(done_cyc),   32'd33);
        check("b2b_load_count", 32'(n_load),     32'd0);
        check("b2b_rxData",     32'(bus.rxData), 32'hC3);

        // Reset asserted during SHIFT cycle 10 aborts the transfer.
        go(8'hF0, 8'h96);
        run_window(9, 0, 0, 0);
        @(posedge Clk);
        #2 Rst_n = 1'b0;
        @(negedge Clk);
        check("midrst_busy",      32'(bus.busy),      32'd0);
        check("midrst_cs_n",      32'(bus.cs_n),      32'd1);
        check("midrst_sclk",      32'(bus.sclk),      32'd0);
        check("midrst_rxData",    32'(bus.rxData),    32'h00);
        check("midrst_shiftData", 32'(bus.shiftData), 32'h00);
        @(negedge Clk);
        Rst_n = 1'b1;
        run_window(40, 0, 0, 0);
        check("midrst_no_done", 32'(n_done), 32'd0);
        check("midrst_no_busy", 32'(n_busy), 32'd0);

        // Recovery transfer after reset.
        go(8'h3C, 8'h81);
        run_window(40, 0, 0, 0);
        check("rec_done_cycle", 32'(done_cyc),   32'd34);
        check("rec_edges",      32'(n_edge),     32'd8);
        check("rec_rxData",     32'(bus.rxData), 32'h81);

`ifdef SHIFT_SEQUENCER_ABORT_EN
        // Abort in SHIFT cycle 12: idle in cycle 13, rxData kept.
        go(8'h11, 8'h7E);
        for (int c = 1; c <= 12; c++) begin
            @(negedge Clk);
            bus.start = 1'b0;
            bus.abort = (c == 12);
        end
        @(negedge Clk);
        bus.abort = 1'b0;
        check("abort_busy",   32'(bus.busy),   32'd0);
        check("abort_cs_n",   32'(bus.cs_n),   32'd1);
        check("abort_rxData", 32'(bus.rxData), 32'h81);
        run_window(40, 0, 0, 0);
        check("abort_no_done", 32'(n_done), 32'd0);
        // Abort together with start in IDLE: start wins and the transfer completes.
        go(8'h22, 8'h5B);
        bus.abort = 1'b1;
        run_window(40, 0, 0, 0);
        check("post_abort_done", 32'(done_cyc),   32'd34);
        check("post_abort_rx",   32'(bus.rxData), 32'h5B);
`endif

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Transfer controller that sequences the 8-bit shift register for one complete serial word. On a start pulse it loads a parallel word into the register, then issues a fixed number of evenly spaced shift strobes while driving a divided serial clock and an active-low chip select. It captures the register's parallel output as the received word and pulses `done`. It sits between the input conditioners and the shift register, replacing the hand-driven load and shift strobes.

## Interface
- `WIDTH`, 8: bits per transfer; also the width of the data buses.
- `DIV`, 4: system clocks per shift strobe; even, ≥2.
- `Clk`  in  1  system clock; all state on rising edge.
- `Rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request, normally a conditioned positive edge.
- `txData`  in  WIDTH  word to transmit; sampled only on an accepted `start`.
- `shiftParOut`  in  WIDTH  shift register parallel output.
- `shiftLoad`  out  1  parallel-load strobe to the shift register.
- `shiftData`  out  WIDTH  parallel-load data to the shift register.
- `shiftEdge`  out  1  one-cycle shift strobe to the shift register.
- `sclk`  out  1  serial clock to the peripheral.
- `cs_n`  out  1  active-low chip select.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle completion pulse.
- `rxData`  out  WIDTH  received word; holds until the next completion.

## Operation
- States: IDLE, LOAD, SHIFT, DONE. Counters: `divCnt` (0..DIV-1) and `bitCnt` (0..WIDTH).
- IDLE: `start` high → latch `txData` into `shiftData` and go to LOAD. Otherwise stay in IDLE.
- LOAD: `shiftLoad`=1 for exactly one cycle. Clear both counters. Go to SHIFT.
- SHIFT: `divCnt` increments each cycle and wraps DIV-1→0.
  - When `divCnt`=DIV-1: `shiftEdge`=1 and `bitCnt` increments.
  - When `bitCnt` reaches WIDTH, go to DONE.
  - `sclk`=1 while `divCnt` ≥ DIV/2; otherwise 0.
- DONE: capture `rxData` ← `shiftParOut`, pulse `done`, then return to IDLE.
- `cs_n`=0 and `busy`=1 in LOAD, SHIFT and DONE. Both are inactive in IDLE.
- `start` outside IDLE is ignored and never queued. This includes `start` in the DONE cycle.
- `shiftLoad` and `shiftEdge` are never high in the same cycle.
- `shiftData` holds its last value when not in LOAD.

## Timing
- Reset values (`Rst_n`=0, effective immediately):
  - State IDLE, counters 0.
  - `shiftLoad`=0, `shiftEdge`=0, `sclk`=0.
  - `cs_n`=1, `busy`=0, `done`=0.
  - `shiftData`=0, `rxData`=0.
- Reset mid-transfer aborts it. No `done` pulse is produced and `rxData` returns to 0.
- All outputs are registered.
- Cycle numbering, with `start` sampled at edge 0:
  - LOAD occupies cycle 1.
  - SHIFT occupies cycles 2 .. 1+WIDTH·DIV.
  - The k-th `shiftEdge` (k=1..WIDTH) falls in cycle 1+k·DIV.
  - DONE occupies cycle 2+WIDTH·DIV.
- `busy` is high for WIDTH·DIV+2 cycles.
- The earliest next accepted `start` is sampled in cycle 3+WIDTH·DIV.
- `rxData` reflects the register state one cycle after the final strobe.

## Configuration
- `SHIFT_SEQUENCER_ABORT_EN` defined:
  - Adds input port `abort` (1 bit).
  - `abort`=1 in LOAD or SHIFT → next state IDLE. `cs_n` and `busy` are inactive the following cycle.
  - No `done` pulse; `rxData` unchanged.
  - `abort` in IDLE or DONE has no effect.
  - `abort` and `start` together in IDLE: `start` wins.
- Undefined: no `abort` port, and every accepted transfer runs to completion.

## Test plan
- Reset: hold `Rst_n`=0, then release → all outputs at their reset values. Assert `Rst_n`=0 in SHIFT cycle 10 → outputs reset in that cycle, no `done`.
- Basic transfer, WIDTH=8, DIV=4, `txData`=8'hA5, `start` at cycle 0:
  - `shiftLoad` in cycle 1 with `shiftData`=8'hA5.
  - `shiftEdge` in cycles 5, 9, …, 33.
  - `done` in cycle 34; `busy` is high for cycles 1–34.
- Receive path: bench model shifts `8'h3C` MSB-first on `shiftEdge` → `rxData`=8'h3C at `done`, held through an idle period of 20 cycles.
- Ignored start: `start` pulses in cycles 10 and 34 → no extra `shiftLoad` and a single `done`. A new `start` at cycle 35 is accepted, giving `shiftLoad` in cycle 36.
- `sclk` and `cs_n` shape: over one transfer `sclk` produces 8 pulses, each 2 cycles high and 2 cycles low. `cs_n` is low for exactly cycles 1–34.
- `SHIFT_SEQUENCER_ABORT_EN`: `abort` in cycle 12 → idle by cycle 13, no `done`, `rxData` unchanged. A following `start` runs a full transfer.
